// File: rtl/cpu_pkg.sv
// cpu_pkg: shared mdOp encodings and multiply/divide FSM states
package cpu_pkg;
  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10
  } md_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } md_state_e;
endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: two's-complement negate when neg is set (magnitude or signed result)
// ports: val in N, neg in 1, res out N
module md_sign_fix #(
  parameter int N = 16
) (
  input  logic [N-1:0] val,
  input  logic         neg,
  output logic [N-1:0] res
);
  assign res = neg ? -val : val;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply / restoring divide, one bit per cycle
// ports: clk, reset (sync, active high), start, mdOp, opA, opB in;
//        busy, done, resultLo, resultHi, divByZero out (all registered)
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mdOp,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultLo,
  output logic [WIDTH-1:0] resultHi,
  output logic             divByZero
);
  localparam int CW = $clog2(WIDTH);
  md_state_e state;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r;
  logic [WIDTH-1:0] dvs;
  logic [2*WIDTH-1:0] p, p_next, prod_fix;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0] sum, r, diff;
  logic accept;
  md_sign_fix #(.N(WIDTH)) u_a (.val(opA), .neg(opA[WIDTH-1]), .res(a_mag));
  md_sign_fix #(.N(WIDTH)) u_b (.val(opB), .neg(opB[WIDTH-1]), .res(b_mag));
  // multiply: p = {partial product, remaining multiplier bits}, shifted right
  // divide:   p = {partial remainder, dividend bits becoming quotient}, shifted left
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, dvs} : '0);
    r = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff = r - {1'b0, dvs};
    p_next = !is_div ? {sum, p[WIDTH-1:1]}
           : diff[WIDTH] ? {r[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
           : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  end
  md_sign_fix #(.N(2*WIDTH)) u_p (.val(p_next), .neg(neg_q), .res(prod_fix));
  md_sign_fix #(.N(WIDTH)) u_q (.val(p_next[WIDTH-1:0]), .neg(neg_q), .res(q_fix));
  md_sign_fix #(.N(WIDTH)) u_r (.val(p_next[2*WIDTH-1:WIDTH]), .neg(neg_r), .res(r_fix));
  assign accept = start && (mdOp == MD_MULT || mdOp == MD_DIV);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dvs <= '0;
      p <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      resultLo <= '0;
      resultHi <= '0;
      divByZero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt <= '0;
          busy <= 1'b1;
          divByZero <= 1'b0;
          is_div <= mdOp == MD_DIV;
          neg_q <= opA[WIDTH-1] ^ opB[WIDTH-1];
          neg_r <= opA[WIDTH-1];
          dvs <= mdOp == MD_DIV ? b_mag : a_mag;
          p <= {{WIDTH{1'b0}}, mdOp == MD_DIV ? a_mag : b_mag};
          if (mdOp == MD_DIV && opB == '0) begin
            state <= S_DONE;
            done <= 1'b1;
            resultLo <= '1;
            resultHi <= opA;
            divByZero <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          p <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_DONE;
            done <= 1'b1;
            resultLo <= is_div ? q_fix : prod_fix[WIDTH-1:0];
            resultHi <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
